// File: rtl/spi_xfer_arbiter.sv
// Round-robin owner of a shared SPI byte engine; sequences CS setup, byte starts, CS hold and gap.
// First eng_start CS_SETUP+1 cycles after grant; starts stall while eng_busy_i is high.
module spi_xfer_arbiter #(
   parameter int NREQ     = 2,
   parameter int CS_SETUP = 4,
   parameter int CS_HOLD  = 4,
   parameter int CS_GAP   = 2
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_i,
   input  logic [8*NREQ-1:0] len_i,
   input  logic [8*NREQ-1:0] tx_data_i,
   output logic [NREQ-1:0]   gnt_o,
   output logic [NREQ-1:0]   tx_ready_o,
   output logic [7:0]        rx_data_o,
   output logic [NREQ-1:0]   rx_valid_o,
   output logic [NREQ-1:0]   done_o,
   output logic [NREQ-1:0]   spi_cs_n_o,
   output logic              eng_start_o,
   output logic [7:0]        eng_tx_o,
   input  logic              eng_busy_i,
   input  logic              eng_done_i,
   input  logic [7:0]        eng_rx_i
);

   localparam int PW   = (NREQ > 2) ? 2 : 1;
   localparam int CMAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                              : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {IDLE, SETUP, LOAD, WAIT, HOLD, GAP} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      rem_q, rem_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   own_q, own_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] cs_n_q, cs_n_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [NREQ-1:0] rx_valid_q, rx_valid_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic [PW-1:0]   sel;
   logic [7:0]      sel_len;

   // Scan from farthest to nearest so the requester right after ptr wins.
   function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] req, input logic [PW-1:0] ptr);
      logic [PW-1:0] pick;
      int            idx;
      pick = ptr;
      for (int i = NREQ; i >= 1; i--) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[PW'(idx)]) pick = PW'(idx);
      end
      return pick;
   endfunction

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         ptr_q      <= PW'(NREQ - 1);
         own_q      <= '0;
         gnt_q      <= '0;
         cs_n_q     <= '1;
         done_q     <= '0;
         rx_valid_q <= '0;
         rx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         ptr_q      <= ptr_d;
         own_q      <= own_d;
         gnt_q      <= gnt_d;
         cs_n_q     <= cs_n_d;
         done_q     <= done_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      ptr_d      = ptr_q;
      own_d      = own_q;
      gnt_d      = gnt_q;
      cs_n_d     = cs_n_q;
      done_d     = '0;
      rx_valid_d = '0;
      rx_data_d  = rx_data_q;
      sel        = rr_pick(req_i, ptr_q);
      sel_len    = len_i[{sel, 3'b000} +: 8];
      case (state_q)
         IDLE: begin
            if (|req_i) begin
               ptr_d      = sel;
               own_d      = sel;
               rem_d      = sel_len;
               gnt_d      = '0;
               gnt_d[sel] = 1'b1;
               cnt_d      = '0;
               if (sel_len != 8'd0) begin
                  cs_n_d      = '1;
                  cs_n_d[sel] = 1'b0;
                  state_d     = SETUP;
               end else begin
                  state_d = GAP;
               end
            end
         end
         SETUP: begin
            if (cnt_q == CW'(CS_SETUP - 1)) begin
               cnt_d   = '0;
               state_d = LOAD;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         LOAD: begin
            if (!eng_busy_i) state_d = WAIT;
         end
         WAIT: begin
            if (eng_done_i) begin
               rx_data_d         = eng_rx_i;
               rx_valid_d[own_q] = 1'b1;
               rem_d             = rem_q - 8'd1;
               if (rem_q == 8'd1) begin
                  cnt_d   = '0;
                  state_d = HOLD;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         HOLD: begin
            if (cnt_q == CW'(CS_HOLD - 1)) begin
               cnt_d   = '0;
               cs_n_d  = '1;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         GAP: begin
            // done and grant release land together, one cycle into the gap.
            if (cnt_q == '0) begin
               done_d[own_q] = 1'b1;
               gnt_d         = '0;
            end
            if (cnt_q == CW'(CS_GAP - 1)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      eng_start_o = 1'b0;
      eng_tx_o    = '0;
      tx_ready_o  = '0;
      if (state_q == LOAD && !eng_busy_i) begin
         eng_start_o       = 1'b1;
         eng_tx_o          = tx_data_i[{own_q, 3'b000} +: 8];
         tx_ready_o[own_q] = 1'b1;
      end
   end

   assign gnt_o      = gnt_q;
   assign spi_cs_n_o = cs_n_q;
   assign done_o     = done_q;
   assign rx_valid_o = rx_valid_q;
   assign rx_data_o  = rx_data_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter: loopback engine model, per-requester byte clients, scoreboard queues.
`timescale 1ns/1ps
module tb_spi_xfer_arbiter;
   localparam int NREQ = 2, CS_SETUP = 3, CS_HOLD = 4, CS_GAP = 2, T = 3;

   logic clk_i = 1'b0;
   logic rst_n;
   logic [NREQ-1:0] req_i;
   logic [8*NREQ-1:0] len_i;
   logic [8*NREQ-1:0] tx_data_i = '0;
   logic [NREQ-1:0] gnt_o, tx_ready_o, rx_valid_o, done_o, spi_cs_n_o;
   logic [7:0] rx_data_o, eng_tx_o;
   logic eng_start_o, eng_busy_i, eng_done_i;
   logic [7:0] eng_rx_i = 8'h00;
   logic eng_busy_m = 1'b0, eng_done_m = 1'b0, force_busy = 1'b0, spur_done = 1'b0;

   assign eng_busy_i = eng_busy_m | force_busy;
   assign eng_done_i = eng_done_m | spur_done;

   spi_xfer_arbiter #(.NREQ(NREQ), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) dut (
      .clk_i(clk_i), .rst_n(rst_n), .req_i(req_i), .len_i(len_i), .tx_data_i(tx_data_i),
      .gnt_o(gnt_o), .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
      .done_o(done_o), .spi_cs_n_o(spi_cs_n_o), .eng_start_o(eng_start_o), .eng_tx_o(eng_tx_o),
      .eng_busy_i(eng_busy_i), .eng_done_i(eng_done_i), .eng_rx_i(eng_rx_i)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0, errors = 0;
   int starts = 0, rxvs = 0, dones = 0, grants = 0, cs_falls = 0;
   int cur_owner = 0, low_run = 0, high_run = 0, since_rxv = -1;
   bit seen_txn = 0, first_byte = 0, setup_chk = 1;
   logic [NREQ-1:0] gnt_prev = '0, low_prev = '0;
   logic [7:0] exp_tx[$], exp_rx[$], cli_q0[$], cli_q1[$];
   int exp_gnt[$], exp_done[$];
   bit eng_phase = 0;
   int eng_cnt = 0;
   logic [7:0] eng_byte = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      logic [NREQ-1:0] lows;
      lows = ~spi_cs_n_o;
      if (gnt_o != '0 && gnt_prev == '0) begin
         grants++;
         if (exp_gnt.size() == 0) check("gnt_spurious", 32'(gnt_o), 0);
         else begin
            cur_owner = exp_gnt.pop_front();
            check("gnt_owner", 32'(gnt_o), 1 << cur_owner);
         end
         first_byte = 1;
      end
      if (lows != '0) check("cs_onehot", $countones(lows), 1);
      if (lows != '0 && low_prev == '0) begin
         cs_falls++;
         check("cs_owner", 32'(lows), 1 << cur_owner);
         if (seen_txn) check("cs_gap", 32'(high_run >= CS_GAP), 1);
         seen_txn  = 1;
         low_run   = 0;
         since_rxv = -1;
      end
      if (lows == '0 && low_prev != '0 && since_rxv >= 0) check("cs_hold", since_rxv, CS_HOLD);
      if (rx_valid_o != '0) begin
         rxvs++;
         since_rxv = 0;
         check("rx_valid_owner", 32'(rx_valid_o), 1 << cur_owner);
         if (exp_rx.size() == 0) check("rx_spurious", 32'(rx_valid_o), 0);
         else check("rx_data", 32'(rx_data_o), 32'(exp_rx.pop_front()));
      end
      if (lows != '0) begin
         low_run++;
         high_run = 0;
         if (since_rxv >= 0) since_rxv++;
      end else begin
         high_run++;
      end
      if (eng_start_o) begin
         starts++;
         if (exp_tx.size() == 0) check("start_spurious", 32'(eng_start_o), 0);
         else check("eng_tx", 32'(eng_tx_o), 32'(exp_tx.pop_front()));
         check("tx_ready", 32'(tx_ready_o), 1 << cur_owner);
         if (first_byte && setup_chk) check("cs_setup", low_run, CS_SETUP + 1);
         first_byte = 0;
      end else if (tx_ready_o != '0) begin
         check("tx_ready_stray", 32'(tx_ready_o), 0);
      end
      if (done_o != '0) begin
         dones++;
         check("done_gnt_low", 32'(gnt_o), 0);
         if (exp_done.size() == 0) check("done_spurious", 32'(done_o), 0);
         else check("done_owner", 32'(done_o), 1 << exp_done.pop_front());
      end
      gnt_prev = gnt_o;
      low_prev = lows;
   endtask

   // Engine loopback, requester byte clients and the output monitor share one timeline:
   // inputs change on the falling edge, outputs are sampled 1ns before the rising edge.
   initial begin
      forever begin
         @(negedge clk_i);
         eng_done_m = 1'b0;
         if (eng_phase) begin
            eng_busy_m = 1'b1;
            if (eng_cnt == 0) begin
               eng_busy_m = 1'b0;
               eng_done_m = 1'b1;
               eng_rx_i   = eng_byte;
               eng_phase  = 0;
            end else eng_cnt--;
         end
         tx_data_i[7:0]  = (cli_q0.size() > 0) ? cli_q0[0] : 8'h00;
         tx_data_i[15:8] = (cli_q1.size() > 0) ? cli_q1[0] : 8'h00;
         #4;
         if (rst_n) monitor();
         else begin
            gnt_prev = gnt_o;
            low_prev = ~spi_cs_n_o;
            high_run++;
         end
         if (!eng_phase && eng_start_o) begin
            eng_byte  = eng_tx_o;
            eng_phase = 1;
            eng_cnt   = T;
         end
         if (tx_ready_o[0] && cli_q0.size() > 0) void'(cli_q0.pop_front());
         if (tx_ready_o[1] && cli_q1.size() > 0) void'(cli_q1.pop_front());
      end
   end

   task automatic add_txn(input int k, input int n, input logic [7:0] b [4]);
      for (int i = 0; i < n; i++) begin
         if (k == 0) cli_q0.push_back(b[i]); else cli_q1.push_back(b[i]);
         exp_tx.push_back(b[i]);
         exp_rx.push_back(b[i]);
      end
      exp_gnt.push_back(k);
      exp_done.push_back(k);
   endtask

   function automatic int get_cnt(input int which);
      case (which)
         0: return starts;
         1: return rxvs;
         2: return dones;
         default: return grants;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int which, input int target, input int budget);
      for (int i = 0; i < budget && get_cnt(which) < target; i++) begin
         @(negedge clk_i);
         #1;
      end
      check(tag, 32'(get_cnt(which) >= target), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_gnt"}, 32'(gnt_o), 0);
      check({tag, "_cs"}, 32'(spi_cs_n_o), 32'(2'b11));
      check({tag, "_done"}, 32'(done_o), 0);
      check({tag, "_rxv"}, 32'(rx_valid_o), 0);
      check({tag, "_rxd"}, 32'(rx_data_o), 0);
      check({tag, "_txr"}, 32'(tx_ready_o), 0);
      check({tag, "_start"}, 32'(eng_start_o), 0);
      check({tag, "_etx"}, 32'(eng_tx_o), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, r0, d0, g0, f0;
      rst_n = 1'b0;
      req_i = '0;
      len_i = '0;
      repeat (3) @(negedge clk_i);
      #4;
      check_reset_outputs("reset");
      @(negedge clk_i);
      rst_n = 1'b1;

      // 1: three-byte transaction from requester 0
      s0 = starts; r0 = rxvs; d0 = dones;
      add_txn(0, 3, '{8'hA5, 8'h3C, 8'hFF, 8'h00});
      len_i[7:0] = 8'd3;
      req_i = 2'b01;
      wait_for("t1_done", 2, d0 + 1, 200);
      req_i = 2'b00;
      check("t1_starts", starts - s0, 3);
      check("t1_rxvs", rxvs - r0, 3);
      check("t1_rx_last", 32'(rx_data_o), 32'h0FF);

      // 3: zero-length transaction never touches CS or the engine
      repeat (4) @(negedge clk_i);
      #1;
      s0 = starts; d0 = dones; g0 = grants; f0 = cs_falls;
      add_txn(0, 0, '{8'h00, 8'h00, 8'h00, 8'h00});
      len_i[7:0] = 8'd0;
      req_i = 2'b01;
      wait_for("t3_done", 2, d0 + 1, 50);
      req_i = 2'b00;
      repeat (3) @(negedge clk_i);
      #4;
      check("t3_grants", grants - g0, 1);
      check("t3_no_start", starts - s0, 0);
      check("t3_no_cs", cs_falls - f0, 0);
      check("t3_cs_high", 32'(spi_cs_n_o), 32'(2'b11));

      // 4: engine held busy for 10 LOAD cycles before the first byte
      @(negedge clk_i);
      #1;
      s0 = starts; d0 = dones; g0 = grants;
      setup_chk = 0;
      add_txn(0, 2, '{8'h5A, 8'hC3, 8'h00, 8'h00});
      len_i[7:0] = 8'd2;
      req_i = 2'b01;
      wait_for("t4_gnt", 3, g0 + 1, 50);
      force_busy = 1'b1;
      repeat (CS_SETUP - 1 + 10) @(negedge clk_i);
      #1;
      check("t4_no_start_busy", starts - s0, 0);
      force_busy = 1'b0;
      #3;
      check("t4_start_after_busy", 32'(eng_start_o), 1);
      check("t4_txr_after_busy", 32'(tx_ready_o), 32'(2'b01));
      wait_for("t4_done", 2, d0 + 1, 200);
      req_i = 2'b00;
      setup_chk = 1;
      check("t4_starts", starts - s0, 2);

      // 6: requester 1 arrives mid-transaction; spurious engine done during HOLD
      repeat (4) @(negedge clk_i);
      #1;
      s0 = starts; r0 = rxvs; d0 = dones;
      add_txn(0, 2, '{8'h66, 8'h99, 8'h00, 8'h00});
      len_i[7:0] = 8'd2;
      req_i = 2'b01;
      wait_for("t6_first_start", 0, s0 + 1, 100);
      add_txn(1, 1, '{8'hE7, 8'h00, 8'h00, 8'h00});
      len_i[15:8] = 8'd1;
      req_i = 2'b11;
      wait_for("t6_rx2", 1, r0 + 2, 200);
      eng_rx_i  = 8'h3F;
      spur_done = 1'b1;
      @(negedge clk_i);
      #1;
      spur_done = 1'b0;
      repeat (2) @(negedge clk_i);
      #4;
      check("t6_spur_rxd", 32'(rx_data_o), 32'h099);
      check("t6_spur_rxv_cnt", rxvs - r0, 2);
      wait_for("t6_done0", 2, d0 + 1, 100);
      req_i = 2'b10;
      wait_for("t6_done1", 2, d0 + 2, 200);
      req_i = 2'b00;
      check("t6_rxvs", rxvs - r0, 3);

      // 5: reset during byte 2 of 4, then 2: both requesting with len 1
      repeat (4) @(negedge clk_i);
      #1;
      s0 = starts;
      add_txn(0, 4, '{8'h01, 8'h02, 8'h03, 8'h04});
      len_i[7:0] = 8'd4;
      req_i = 2'b01;
      wait_for("t5_second_start", 0, s0 + 2, 200);
      d0 = dones;
      rst_n = 1'b0;
      req_i = 2'b00;
      exp_tx.delete(); exp_rx.delete(); exp_gnt.delete(); exp_done.delete();
      cli_q0.delete(); cli_q1.delete();
      @(negedge clk_i);
      #4;
      check_reset_outputs("abort");
      @(negedge clk_i);
      rst_n = 1'b1;
      repeat (8) @(negedge clk_i);
      #1;
      check("t5_no_done", dones - d0, 0);
      d0 = dones; g0 = grants;
      add_txn(0, 1, '{8'h11, 8'h00, 8'h00, 8'h00});
      add_txn(1, 1, '{8'h22, 8'h00, 8'h00, 8'h00});
      add_txn(0, 1, '{8'h33, 8'h00, 8'h00, 8'h00});
      add_txn(1, 1, '{8'h44, 8'h00, 8'h00, 8'h00});
      len_i = {8'd1, 8'd1};
      req_i = 2'b11;
      wait_for("t2_done4", 2, d0 + 4, 400);
      req_i = 2'b00;
      repeat (6) @(negedge clk_i);
      #4;
      check("t2_grants", grants - g0, 4);
      check("t2_idle_cs", 32'(spi_cs_n_o), 32'(2'b11));
      check("t2_idle_gnt", 32'(gnt_o), 0);
      check("t2_queues_empty", exp_rx.size() + exp_gnt.size() + exp_done.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
